// File: rtl/rv_scoreboard.sv
// Register scoreboard: tracks remaining result latency per destination register and
// derives issue stall, per-source forwarding, WAW ordering and flush cleanup from it.
module rv_scoreboard #(
  parameter int NREG      = 32,
  parameter int AW        = 5,
  parameter int LAT_W     = 3,
  parameter int FLUSH_MIN = 2,
  parameter int PERF_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic              issue_wen,
  input  logic [AW-1:0]     issue_rd,
  input  logic [LAT_W-1:0]  issue_lat,
  input  logic              rs1_en,
  input  logic [AW-1:0]     rs1_addr,
  input  logic              rs2_en,
  input  logic [AW-1:0]     rs2_addr,
  input  logic              flush,
  output logic              issue_ready,
  output logic              rs1_fwd,
  output logic              rs2_fwd,
  output logic [AW:0]       busy_cnt,
  output logic [PERF_W-1:0] stall_cnt
);

  logic [LAT_W-1:0] cnt     [NREG];
  logic [LAT_W-1:0] cnt_nxt [NREG];
  logic [AW:0]      busy_nxt;

  logic [LAT_W-1:0] rs1_cnt, rs2_cnt, rd_cnt, lat_eff;
  logic             rs1_live, rs2_live, rd_live;
  logic             rs1_haz, rs2_haz, waw_haz;
  logic             accept, write_rd;

  assign rs1_cnt  = cnt[rs1_addr];
  assign rs2_cnt  = cnt[rs2_addr];
  assign rd_cnt   = cnt[issue_rd];

  assign rs1_live = rs1_en && (rs1_addr != '0);
  assign rs2_live = rs2_en && (rs2_addr != '0);
  assign rd_live  = issue_wen && (issue_rd != '0);

  // A count of exactly one means the producer drives the forward bus this cycle.
  assign rs1_haz  = rs1_live && (rs1_cnt > LAT_W'(1));
  assign rs2_haz  = rs2_live && (rs2_cnt > LAT_W'(1));
  assign rs1_fwd  = rs1_live && (rs1_cnt == LAT_W'(1));
  assign rs2_fwd  = rs2_live && (rs2_cnt == LAT_W'(1));
  assign waw_haz  = rd_live && (rd_cnt > issue_lat);

  assign issue_ready = !(issue_valid && (rs1_haz || rs2_haz || waw_haz)) && !flush;
  assign accept      = issue_valid && issue_ready;
  assign write_rd    = accept && rd_live;
  assign lat_eff     = (issue_lat == '0) ? LAT_W'(1) : issue_lat;

  // Next-state counters: flush kill or decrement, with a fresh issue write taking priority.
  always_comb begin
    busy_nxt   = '0;
    cnt_nxt[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      if (flush && (cnt[r] >= LAT_W'(FLUSH_MIN)))
        cnt_nxt[r] = '0;
      else if (cnt[r] != '0)
        cnt_nxt[r] = cnt[r] - LAT_W'(1);
      else
        cnt_nxt[r] = '0;
      if (write_rd && (issue_rd == AW'(r)))
        cnt_nxt[r] = lat_eff;
      if (cnt_nxt[r] != '0)
        busy_nxt = busy_nxt + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= '0;
      busy_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      for (int r = 0; r < NREG; r++)
        cnt[r] <= cnt_nxt[r];
      busy_cnt <= busy_nxt;
      // Flush-induced non-acceptance is not a hazard stall and is not counted.
      if (issue_valid && !issue_ready && !flush && (stall_cnt != '1))
        stall_cnt <= stall_cnt + PERF_W'(1);
    end
  end

endmodule
